ram_arbiter: RTL
================

RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of each requester and the RAM port.
REQ-002 Parameter: DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 Port: clk  input  1  single system clock; all state on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: m_req[1:0]  input  2  per-requester access request; index 0 = core data port, 1 = loader/DMA.
REQ-006 Port: m_we[1:0]  input  2  per-requester write (1) / read (0).
REQ-007 Port: m_lock[1:0]  input  2  per-requester hold-grant request for back-to-back accesses.
REQ-008 Port: m_addr0, m_addr1  input  ADDR_W each  requester addresses.
REQ-009 Port: m_wdata0, m_wdata1  input  DATA_W each  requester write data.
REQ-010 Port: m_be0, m_be1  input  DATA_W/8 each  requester byte enables.
REQ-011 Port: m_gnt[1:0]  output  2  access accepted this cycle, one-hot or zero.
REQ-012 Port: m_rvalid[1:0]  output  2  read data valid for that requester.
REQ-013 Port: m_rdata  output  DATA_W  registered read data, shared by both requesters.
REQ-014 Port: MemRead, MemWrite  output  1 each  RAM strobes.
REQ-015 Port: byte_enable  output  DATA_W/8  RAM byte lanes; addr  output  ADDR_W; w_data  output  DATA_W.
REQ-016 Port: r_data  input  DATA_W  combinational RAM read data.

Function
REQ-017 Grant shall be combinational: m_gnt[i]=1 in the same cycle as m_req[i]=1 when requester i wins; RAM outputs mux the winner's addr/wdata/be.
REQ-018 MemRead = granted & ~we; MemWrite = granted & we; both 0 and byte_enable 0 when no grant.
REQ-019 Read latency one cycle: r_data is captured on the granting edge; m_rvalid[i]=1 and m_rdata valid in the next cycle only; writes never raise m_rvalid.
REQ-020 FSM states ARB, HOLD0, HOLD1; ARB -> HOLDi when i is granted with m_lock[i]=1.
REQ-021 In HOLDi only requester i may be granted; the other is held off (m_gnt=0) regardless of request.
REQ-022 HOLDi -> ARB on a cycle where m_req[i]=0 or m_lock[i]=0; that cycle's access (if m_req[i]=1) is still granted to i.
REQ-023 Simultaneous requests in ARB are resolved per REQ-031/032; a single requester is always granted in ARB.
REQ-024 last_gnt register records the most recent granted index, updated on every grant.
REQ-025 m_rdata holds its previous value when m_rvalid is 0.

Reset
REQ-026 On rst_n=0 asynchronously: state=ARB, last_gnt=1 (so index 0 wins first), m_rvalid=0, m_rdata=0.
REQ-027 During reset m_gnt, MemRead, MemWrite, byte_enable shall be 0.
REQ-028 Reset mid-burst shall abandon HOLDi and discard any pending rvalid.

Configuration
REQ-029 Macro RAM_ARB_RR_EN selects the ARB-state tie-break policy.
REQ-030 Policy affects only simultaneous requests in ARB; HOLD behaviour unchanged.
REQ-031 With RAM_ARB_RR_EN defined: round-robin, winner = index != last_gnt.
REQ-032 Without it: fixed priority, index 0 always wins; last_gnt still maintained.

Structure
REQ-033 Package ram_arb_pkg: enum arb_state_t {ARB, HOLD0, HOLD1}, NUM_REQ=2, default width constants.
REQ-034 One sub-module ram_arb_picker: combinational winner selection from req, state, last_gnt.
REQ-035 Read-data register, FSM and RAM mux live in ram_arbiter.

Verification
REQ-036 Reset release, m_req=01, m_we0=0, m_addr0=0x10, RAM word 0x10=0xDEADBEEF -> m_gnt=01 same cycle, next cycle m_rvalid=01, m_rdata=0xDEADBEEF.
REQ-037 m_req=11 held 4 cycles, no lock, RR build -> grants 01,10,01,10; fixed build -> 01,01,01,01.
REQ-038 Requester 1 writes 0x12345678 be=0011 to 0x20, then requester 0 reads 0x20 (prior 0) -> m_rdata=0x00005678, no m_rvalid on write.
REQ-039 Requester 1 lock=1 for 3 accesses while m_req0=1 -> m_gnt=10 for 3 cycles, requester 0 granted the cycle after lock drops.
REQ-040 rst_n asserted in HOLD1 with read in flight -> m_rvalid=00, state ARB, next simultaneous request granted to index 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the two-requester RAM arbiter.
package ram_arb_pkg;

  localparam int unsigned NUM_REQ    = 2;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/ram_arb_picker.sv
// Combinational winner selection. Tie-break policy: RAM_ARB_RR_EN defined selects
// round-robin, otherwise requester 0 has fixed priority.
module ram_arb_picker
  import ram_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  arb_state_t         state_i,
  input  logic               last_gnt_i,
  output logic [NUM_REQ-1:0] gnt_o
);

`ifdef RAM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic tie_winner;

  always_comb begin
    tie_winner = RR_EN ? ~last_gnt_i : 1'b0;
    gnt_o      = '0;
    case (state_i)
      HOLD0:   gnt_o[0] = req_i[0];
      HOLD1:   gnt_o[1] = req_i[1];
      default: begin
        if (&req_i) gnt_o[tie_winner] = 1'b1;
        else        gnt_o = req_i;
      end
    endcase
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester single-port RAM arbiter with lock/hold bursts and one-cycle reads.
// Tie-break policy selected by RAM_ARB_RR_EN (see ram_arb_picker).
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          m_req,
  input  logic [1:0]          m_we,
  input  logic [1:0]          m_lock,
  input  logic [ADDR_W-1:0]   m_addr0,
  input  logic [ADDR_W-1:0]   m_addr1,
  input  logic [DATA_W-1:0]   m_wdata0,
  input  logic [DATA_W-1:0]   m_wdata1,
  input  logic [DATA_W/8-1:0] m_be0,
  input  logic [DATA_W/8-1:0] m_be1,
  output logic [1:0]          m_gnt,
  output logic [1:0]          m_rvalid,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                MemRead,
  output logic                MemWrite,
  output logic [DATA_W/8-1:0] byte_enable,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W-1:0]   r_data
);

  arb_state_t          state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic [1:0]          pick;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  ram_arb_picker u_picker (
    .req_i      (m_req),
    .state_i    (state_q),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (pick)
  );

  // Grant is gated by rst_n so no strobe reaches the RAM while reset is held.
  always_comb begin
    m_gnt       = rst_n ? pick : 2'b00;
    addr        = m_gnt[1] ? m_addr1 : m_addr0;
    w_data      = m_gnt[1] ? m_wdata1 : m_wdata0;
    byte_enable = '0;
    if (|m_gnt) byte_enable = m_gnt[1] ? m_be1 : m_be0;
    MemRead     = |(m_gnt & ~m_we);
    MemWrite    = |(m_gnt & m_we);
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    rvalid_d   = m_gnt & ~m_we;
    rdata_d    = rdata_q;
    if (|m_gnt)    last_gnt_d = m_gnt[1];
    if (|rvalid_d) rdata_d    = r_data;
    case (state_q)
      ARB: begin
        if (m_gnt[0] && m_lock[0])      state_d = HOLD0;
        else if (m_gnt[1] && m_lock[1]) state_d = HOLD1;
      end
      HOLD0:   if (!m_req[0] || !m_lock[0]) state_d = ARB;
      HOLD1:   if (!m_req[1] || !m_lock[1]) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      last_gnt_q <= 1'b1;
      rvalid_q   <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

  assign m_rvalid = rvalid_q;
  assign m_rdata  = rdata_q;

endmodule
